// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_ctrl_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUCTL_W = 3;
    localparam int unsigned STATE_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    localparam logic [ALUCTL_W-1:0] ALUCTL_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SUB = 3'b110;
    localparam logic [ALUCTL_W-1:0] ALUCTL_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALUCTL_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SLT = 3'b111;

    // True when the opcode belongs to the supported ISA subset.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control-unit <-> datapath signal bundle; master is the control unit.
interface mips_multicycle_ctrl_if;
    import mips_ctrl_pkg::*;

    logic [OP_W-1:0]     op;
    logic [FUNCT_W-1:0]  funct;
    logic                zero;
    logic                iord;
    logic                memwrite;
    logic                irwrite;
    logic                regdst;
    logic                memtoreg;
    logic                regwrite;
    logic                alusrca;
    logic [1:0]          alusrcb;
    logic [1:0]          pcsrc;
    logic                pcen;
    logic [ALUCTL_W-1:0] alucontrol;
    logic                illegal_op;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pcen, alucontrol, illegal_op
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pcen, alucontrol, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps aluop and funct to the 3-bit ALU operation.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t              aluop,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUCTL_W-1:0] alucontrol
);

    // Unknown funct and the reserved aluop fall back to add.
    always_comb begin
        alucontrol = ALUCTL_ADD;
        case (aluop)
            ALUOP_SUB:   alucontrol = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALUCTL_ADD;
                    FUNCT_SUB: alucontrol = ALUCTL_SUB;
                    FUNCT_AND: alucontrol = ALUCTL_AND;
                    FUNCT_OR:  alucontrol = ALUCTL_OR;
                    FUNCT_SLT: alucontrol = ALUCTL_SLT;
                    default:   alucontrol = ALUCTL_ADD;
                endcase
            end
            default:     alucontrol = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM driving datapath enables and ALU control.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus
);

    state_t state;
    state_t state_next;
    state_t state_eff;
    aluop_t aluop;
    logic   pcwrite;
    logic   branch;

    // State register; synchronous active-low reset returns to FETCH.
    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    // Next-state logic; anything not explicitly listed returns to FETCH.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:   state_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW)      state_next = S_MEMRD;
                else if (bus.op == OP_SW) state_next = S_MEMWR;
            end
            S_MEMRD:   state_next = S_MEMWB;
            S_RTYPEEX: state_next = S_RTYPEWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // During reset the datapath sees FETCH-style selects with every enable held low.
    assign state_eff = reset ? state : S_FETCH;

    // Moore outputs decoded from the (effective) state; pcen also folds in zero.
    always_comb begin
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.illegal_op = 1'b0;
        aluop          = ALUOP_ADD;
        pcwrite        = 1'b0;
        branch         = 1'b0;
        case (state_eff)
            S_FETCH: begin
                bus.irwrite = 1'b1;
                pcwrite     = 1'b1;
                bus.alusrcb = 2'b01;
            end
            S_DECODE: begin
                bus.alusrcb    = 2'b11;
                bus.illegal_op = !is_legal_op(bus.op);
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD:   bus.iord = 1'b1;
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BEQEX: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_SUB;
                branch      = 1'b1;
                bus.pcsrc   = 2'b01;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_ADDIWB:  bus.regwrite = 1'b1;
            S_JEX: begin
                pcwrite   = 1'b1;
                bus.pcsrc = 2'b10;
            end
            default: ;
        endcase
        bus.pcen = pcwrite | (branch & bus.zero);
        if (!reset) begin
            bus.memwrite   = 1'b0;
            bus.irwrite    = 1'b0;
            bus.regwrite   = 1'b0;
            bus.pcen       = 1'b0;
            bus.illegal_op = 1'b0;
        end
    end

    // ALU operation select.
    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench for the multicycle MIPS control unit.
module tb_mips_multicycle_ctrl;

    localparam int C_LW   = 0;
    localparam int C_SW   = 1;
    localparam int C_R    = 2;
    localparam int C_BEQ  = 3;
    localparam int C_ADDI = 4;
    localparam int C_J    = 5;
    localparam int C_ILL  = 6;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed output vector against the expected one.
    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output vector: iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb pcsrc pcen alucontrol illegal_op
    function automatic logic [15:0] pack(input logic iord, input logic memwrite, input logic irwrite,
                                         input logic regdst, input logic memtoreg, input logic regwrite,
                                         input logic alusrca, input logic [1:0] alusrcb, input logic [1:0] pcsrc,
                                         input logic pcen, input logic [2:0] aluctl, input logic ill);
        return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, pcen, aluctl, ill};
    endfunction

    function automatic logic [15:0] observed();
        return pack(bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
                    bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen, bus.alucontrol, bus.illegal_op);
    endfunction

    function automatic int instr_len(input int cls);
        case (cls)
            C_LW:               return 5;
            C_SW, C_R, C_ADDI:  return 4;
            C_BEQ, C_J:         return 3;
            default:            return 2;
        endcase
    endfunction

    function automatic logic [2:0] r_aluctl(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs in cycle k of an instruction of class cls (k=0 is fetch, k=1 decode).
    function automatic logic [15:0] model(input int cls, input logic [5:0] fn, input logic z, input int k);
        logic iord = 0, mw = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, asa = 0, pcen = 0, ill = 0;
        logic [1:0] asb = 2'b00, pcs = 2'b00;
        logic [2:0] actl = 3'b010;
        if (k == 0) begin
            irw = 1; pcen = 1; asb = 2'b01;
        end else if (k == 1) begin
            asb = 2'b11; ill = (cls == C_ILL);
        end else begin
            case (cls)
                C_LW: begin
                    if (k == 2) begin asa = 1; asb = 2'b10; end
                    if (k == 3) iord = 1;
                    if (k == 4) begin rw = 1; m2r = 1; end
                end
                C_SW: begin
                    if (k == 2) begin asa = 1; asb = 2'b10; end
                    if (k == 3) begin iord = 1; mw = 1; end
                end
                C_R: begin
                    if (k == 2) begin asa = 1; actl = r_aluctl(fn); end
                    if (k == 3) begin rdst = 1; rw = 1; end
                end
                C_BEQ: begin
                    asa = 1; pcs = 2'b01; actl = 3'b110; pcen = z;
                end
                C_ADDI: begin
                    if (k == 2) begin asa = 1; asb = 2'b10; end
                    if (k == 3) rw = 1;
                end
                C_J: begin
                    pcen = 1; pcs = 2'b10;
                end
                default: ;
            endcase
        end
        return pack(iord, mw, irw, rdst, m2r, rw, asa, asb, pcs, pcen, actl, ill);
    endfunction

    // While reset is low: fetch selects, no enables.
    function automatic logic [15:0] rst_model();
        return pack(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 3'b010, 0);
    endfunction

    function automatic logic [5:0] op_of(input int cls);
        case (cls)
            C_LW:   return 6'b100011;
            C_SW:   return 6'b101011;
            C_R:    return 6'b000000;
            C_BEQ:  return 6'b000100;
            C_ADDI: return 6'b001000;
            C_J:    return 6'b000010;
            default: return 6'b111111;
        endcase
    endfunction

    function automatic logic [5:0] rand_illegal_op();
        logic [5:0] o;
        do o = 6'($urandom_range(0, 63));
        while (o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
               o == 6'b000100 || o == 6'b001000 || o == 6'b000010);
        return o;
    endfunction

    // Step one instruction cycle by cycle; abort_at>=0 pulls reset low in that cycle and stops.
    task automatic run_instr(input string name, input int cls, input logic [5:0] opv, input logic [5:0] fn,
                             input int abort_at, input int zmode);
        logic [15:0] exp;
        for (int k = 0; k < instr_len(cls); k++) begin
            @(negedge clk);
            reset     = (k == abort_at) ? 1'b0 : 1'b1;
            bus.op    = opv;
            bus.funct = fn;
            bus.zero  = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            exp = reset ? model(cls, fn, bus.zero, k) : rst_model();
            check_eq($sformatf("%s k%0d", name, k), observed(), exp);
            if (k == abort_at) break;
        end
    endtask

    initial begin
        logic [5:0] fn_list [5];
        logic [5:0] fn;
        int cls;
        int ab;
        n_cmp = 0;
        n_err = 0;
        fn_list[0] = 6'b100000;
        fn_list[1] = 6'b100010;
        fn_list[2] = 6'b100100;
        fn_list[3] = 6'b100101;
        fn_list[4] = 6'b101010;
        reset     = 1'b0;
        bus.op    = 6'b100011;
        bus.funct = 6'b0;
        bus.zero  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.op   = 6'($urandom_range(0, 63));
            bus.zero = 1'($urandom_range(0, 1));
            #1;
            check_eq("reset", observed(), rst_model());
        end

        run_instr("lw", C_LW, op_of(C_LW), 6'h15, -1, -1);
        for (int i = 0; i < 5; i++)
            run_instr("rtype", C_R, op_of(C_R), fn_list[i], -1, -1);
        run_instr("beq_z1", C_BEQ, op_of(C_BEQ), 6'h00, -1, 1);
        run_instr("beq_z0", C_BEQ, op_of(C_BEQ), 6'h00, -1, 0);
        run_instr("j", C_J, op_of(C_J), 6'h22, -1, -1);
        run_instr("sw", C_SW, op_of(C_SW), 6'h22, -1, -1);
        run_instr("addi", C_ADDI, op_of(C_ADDI), 6'h2a, -1, -1);
        run_instr("ill_3f", C_ILL, 6'b111111, 6'h00, -1, -1);
        run_instr("lw_abort", C_LW, op_of(C_LW), 6'h00, 3, -1);
        run_instr("after_abort", C_J, op_of(C_J), 6'h00, -1, -1);

        for (int n = 0; n < 400; n++) begin
            cls = $urandom_range(0, 6);
            if (cls == C_R && $urandom_range(0, 5) != 0) fn = fn_list[$urandom_range(0, 4)];
            else fn = 6'($urandom_range(0, 63));
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, instr_len(cls) - 1) : -1;
            run_instr("rand", cls, (cls == C_ILL) ? rand_illegal_op() : op_of(cls), fn, ab, -1);
        end
        run_instr("final_fetch", C_ILL, 6'b111111, 6'h00, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
